// File: rtl/float_fix_pkg.sv
// ============================================================================
// Module      : float_fix_pkg
// Description : IEEE-754 single-precision field constants, frame sequencer
//               state encoding and fixed-point width helper shared by the
//               float-to-fixed frame converter.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package float_fix_pkg;

    localparam int         SIGN_BIT    = 31;
    localparam int         EXP_MSB     = 30;
    localparam int         EXP_LSB     = 23;
    localparam int         MAN_BITS    = 23;
    localparam int         EXP_BIAS    = 127;
    localparam logic [7:0] EXP_SPECIAL = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_CONVERT = 2'd2,
        ST_PRESENT = 2'd3
    } state_e;

    // Total fixed-point word width (sign bit lives inside the integer part)
    function automatic int fix_width(input int int_w, input int fract_w);
        return int_w + fract_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/float_frame_converter_if.sv
// ============================================================================
// Module      : float_frame_converter_if
// Description : Input word stream and parallel frame output bundle of the
//               float-to-fixed frame converter.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface float_frame_converter_if #(
    parameter int NUM_CH = 6,
    parameter int W      = 16
) ();

    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           in_data;
    logic                  in_last;
    logic                  frame_valid;
    logic                  frame_ready;
    logic [NUM_CH*W-1:0]   frame_data;
    logic [NUM_CH-1:0]     frame_sat;
    logic                  frame_short;
    logic                  busy;

    // Converter side
    modport slave (
        input  in_valid, in_data, in_last, frame_ready,
        output in_ready, frame_valid, frame_data, frame_sat, frame_short, busy
    );

    // Producer / consumer side
    modport master (
        output in_valid, in_data, in_last, frame_ready,
        input  in_ready, frame_valid, frame_data, frame_sat, frame_short, busy
    );

endinterface

`default_nettype wire

// File: rtl/float_fix_conv_sat.sv
// ============================================================================
// Module      : float_fix_conv_sat
// Description : Combinational IEEE-754 single to signed fixed-point converter
//               with round-to-nearest, saturation and NaN/Inf handling.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module float_fix_conv_sat
    import float_fix_pkg::*;
#(
    parameter int INT_WIDTH   = 8,
    parameter int FRACT_WIDTH = 8,
    localparam int W          = fix_width(INT_WIDTH, FRACT_WIDTH)
) (
    input  logic [31:0]  i_word,
    output logic [W-1:0] o_value,
    output logic         o_flag
);

    localparam logic [63:0]  POS_LIMIT = (64'd1 << (W-1)) - 64'd1;
    localparam logic [63:0]  NEG_LIMIT = 64'd1 << (W-1);
    localparam logic [W-1:0] VAL_MAX   = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] VAL_MIN   = {1'b1, {(W-1){1'b0}}};

    logic        w_sign;
    logic [7:0]  w_exp;
    logic [22:0] w_man;
    logic [23:0] w_sig;
    int          w_shift;
    logic [63:0] w_mag;

    // Magnitude scaled by 2^FRACT_WIDTH; right shifts round half away from zero
    always_comb begin
        w_sign  = i_word[SIGN_BIT];
        w_exp   = i_word[EXP_MSB:EXP_LSB];
        w_man   = i_word[MAN_BITS-1:0];
        w_sig   = {1'b1, w_man};
        w_shift = int'(w_exp) - (EXP_BIAS + MAN_BITS) + FRACT_WIDTH;
        if (w_shift >= 0) begin
            w_mag = {40'd0, w_sig} << w_shift;
        end else begin
            w_mag = ((({40'd0, w_sig}) >> (-w_shift - 1)) + 64'd1) >> 1;
        end
    end

    // Special-value, range and sign resolution
    always_comb begin
        o_value = '0;
        o_flag  = 1'b0;
        if (w_exp == EXP_SPECIAL) begin
            o_flag = 1'b1;
            if (w_man != 23'd0) o_value = '0;
            else                o_value = w_sign ? VAL_MIN : VAL_MAX;
        end else if (w_exp == 8'd0) begin
            // Zero and denormals are far below one LSB
            o_value = '0;
        end else if (int'(w_exp) >= EXP_BIAS + INT_WIDTH - 1) begin
            o_flag  = 1'b1;
            o_value = w_sign ? VAL_MIN : VAL_MAX;
        end else if (!w_sign) begin
            if (w_mag > POS_LIMIT) begin
                o_flag  = 1'b1;
                o_value = VAL_MAX;
            end else begin
                o_value = w_mag[W-1:0];
            end
        end else begin
            if (w_mag > NEG_LIMIT) begin
                o_flag  = 1'b1;
                o_value = VAL_MIN;
            end else begin
                o_value = (~w_mag[W-1:0]) + W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/float_frame_converter.sv
// ============================================================================
// Module      : float_frame_converter
// Description : Captures a burst of IEEE-754 sensor words, converts them one
//               per cycle through a shared float-to-fixed converter and
//               presents the whole frame as a parallel fixed-point bus.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module float_frame_converter
    import float_fix_pkg::*;
#(
    parameter int NUM_CH      = 6,
    parameter int INT_WIDTH   = 8,
    parameter int FRACT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    float_frame_converter_if.slave bus
);

    localparam int                W        = fix_width(INT_WIDTH, FRACT_WIDTH);
    localparam int                IDX_W    = $clog2(NUM_CH);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_CH - 1);

    state_e              state_q,  state_d;
    logic [IDX_W-1:0]    wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0]    rd_idx_q, rd_idx_d;
    logic [31:0]         cap_q [NUM_CH];
    logic [31:0]         cap_d [NUM_CH];
    logic [NUM_CH*W-1:0] data_q,   data_d;
    logic [NUM_CH-1:0]   sat_q,    sat_d;
    logic                short_q,  short_d;
    logic                w_in_ready;
    logic                w_frame_valid;
    logic [W-1:0]        w_conv_value;
    logic                w_conv_flag;

    // Single shared converter, fed from the capture slot being converted
    float_fix_conv_sat #(
        .INT_WIDTH   (INT_WIDTH),
        .FRACT_WIDTH (FRACT_WIDTH)
    ) u_conv (
        .i_word  (cap_q[rd_idx_q]),
        .o_value (w_conv_value),
        .o_flag  (w_conv_flag)
    );

    // Sequencer next state: capture, convert one slot per cycle, present
    always_comb begin
        state_d       = state_q;
        wr_idx_d      = wr_idx_q;
        rd_idx_d      = rd_idx_q;
        cap_d         = cap_q;
        data_d        = data_q;
        sat_d         = sat_q;
        short_d       = short_q;
        w_in_ready    = 1'b0;
        w_frame_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    cap_d[0] = bus.in_data;
                    if (bus.in_last) begin
                        // A one-word frame is always short
                        short_d  = 1'b1;
                        wr_idx_d = '0;
                        state_d  = ST_CONVERT;
                    end else begin
                        wr_idx_d = IDX_W'(1);
                        state_d  = ST_CAPTURE;
                    end
                end
            end
            ST_CAPTURE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    cap_d[wr_idx_q] = bus.in_data;
                    if (bus.in_last || (wr_idx_q == LAST_IDX)) begin
                        short_d  = bus.in_last && (wr_idx_q != LAST_IDX);
                        wr_idx_d = '0;
                        state_d  = ST_CONVERT;
                    end else begin
                        wr_idx_d = wr_idx_q + IDX_W'(1);
                    end
                end
            end
            ST_CONVERT: begin
                data_d[rd_idx_q*W +: W] = w_conv_value;
                sat_d[rd_idx_q]         = w_conv_flag;
                if (rd_idx_q == LAST_IDX) begin
                    rd_idx_d = '0;
                    state_d  = ST_PRESENT;
                end else begin
                    rd_idx_d = rd_idx_q + IDX_W'(1);
                end
            end
            ST_PRESENT: begin
                w_frame_valid = 1'b1;
                if (bus.frame_ready) begin
                    // Empty the capture buffer so a later short frame sees zeros
                    cap_d    = '{default: '0};
                    wr_idx_d = '0;
                    rd_idx_d = '0;
                    sat_d    = '0;
                    short_d  = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            cap_q    <= '{default: '0};
            data_q   <= '0;
            sat_q    <= '0;
            short_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            cap_q    <= cap_d;
            data_q   <= data_d;
            sat_q    <= sat_d;
            short_q  <= short_d;
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.frame_valid = w_frame_valid;
    assign bus.frame_data  = data_q;
    assign bus.frame_sat   = sat_q;
    assign bus.frame_short = short_q;
    assign bus.busy        = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_float_frame_converter.sv
// ============================================================================
// Module      : tb_float_frame_converter
// Description : Scoreboard bench for float_frame_converter with directed
//               frames: full, short, saturating, gapped, backpressured and
//               reset in the middle of conversion.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_float_frame_converter;

    localparam int NUM_CH      = 6;
    localparam int INT_WIDTH   = 8;
    localparam int FRACT_WIDTH = 8;
    localparam int W           = 16;
    localparam int DW          = NUM_CH * W;

    // 0.5, 1.0, 3.75, -2.5, 0.1688, 1.0000001
    localparam logic [NUM_CH*32-1:0] F1_W = {32'h3F800001, 32'h3E2CD9DF, 32'hC0200000,
                                             32'h40700000, 32'h3F800000, 32'h3F000000};
    localparam logic [DW-1:0]        F1_D = {16'h0100, 16'h002B, 16'hFD80,
                                             16'h03C0, 16'h0100, 16'h0080};
    // 2.0, -0.5, 2^-8 then in_last
    localparam logic [NUM_CH*32-1:0] SH_W = {32'h0, 32'h0, 32'h0,
                                             32'h3B800000, 32'hBF000000, 32'h40000000};
    localparam logic [DW-1:0]        SH_D = {16'h0000, 16'h0000, 16'h0000,
                                             16'h0001, 16'hFF80, 16'h0200};
    // 1024.0, -1024.0, 127.999, +Inf, NaN, -1.0
    localparam logic [NUM_CH*32-1:0] ST_W = {32'hBF800000, 32'h7FC00000, 32'h7F800000,
                                             32'h42FFFF7D, 32'hC4800000, 32'h44800000};
    localparam logic [DW-1:0]        ST_D = {16'hFF00, 16'h0000, 16'h7FFF,
                                             16'h7FFF, 16'h8000, 16'h7FFF};

    typedef struct packed {
        logic [DW-1:0]     data;
        logic [NUM_CH-1:0] sat;
        logic              short_f;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    float_frame_converter_if #(.NUM_CH(NUM_CH), .W(W)) bus ();

    float_frame_converter #(
        .NUM_CH      (NUM_CH),
        .INT_WIDTH   (INT_WIDTH),
        .FRACT_WIDTH (FRACT_WIDTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pop and compare on every frame handshake
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.frame_valid && bus.frame_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got frame %h expected no frame", bus.frame_data);
                end else begin
                    mon_e = sb.pop_front();
                    chk("frame_data",  bus.frame_data,  mon_e.data);
                    chk("frame_sat",   bus.frame_sat,   mon_e.sat);
                    chk("frame_short", bus.frame_short, mon_e.short_f);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic send_word(input logic [31:0] d, input logic last);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        while (!bus.in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got in_ready=0 expected 1 within 100 cycles");
        end else begin
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic run_frame(input logic [NUM_CH*32-1:0] words, input int n,
                             input logic [DW-1:0] exp_d, input logic [NUM_CH-1:0] exp_s,
                             input logic exp_sh, input bit gap, input bit push,
                             input bit check_lat);
        int lat;
        if (push) sb.push_back('{data: exp_d, sat: exp_s, short_f: exp_sh});
        for (int k = 0; k < n; k++) begin
            send_word(words[k*32 +: 32], (k == n - 1));
            if (gap && k < n - 1) begin
                @(posedge clk); #1;
            end
        end
        if (check_lat) begin
            lat = 0;
            while (!bus.frame_valid && lat < 50) begin
                @(posedge clk); #1;
                lat++;
            end
            chk("frame_latency", lat, NUM_CH);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_in_ready"},    bus.in_ready,    1'b1);
        chk({tag, "_frame_valid"}, bus.frame_valid, 1'b0);
        chk({tag, "_frame_data"},  bus.frame_data,  '0);
        chk({tag, "_frame_sat"},   bus.frame_sat,   '0);
        chk({tag, "_frame_short"}, bus.frame_short, 1'b0);
        chk({tag, "_busy"},        bus.busy,        1'b0);
    endtask

    initial begin
        int n;
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.in_last     = 1'b0;
        bus.frame_ready = 1'b1;
        #12;
        chk_reset_values("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Back-to-back full frame, then a short frame reusing the buffer
        run_frame(F1_W, 6, F1_D, 6'b000000, 1'b0, 1'b0, 1'b1, 1'b1);
        run_frame(SH_W, 3, SH_D, 6'b000000, 1'b1, 1'b0, 1'b1, 1'b1);
        run_frame(ST_W, 6, ST_D, 6'b011111, 1'b0, 1'b0, 1'b1, 1'b1);
        run_frame(F1_W, 6, F1_D, 6'b000000, 1'b0, 1'b1, 1'b1, 1'b1);

        // Backpressure: hold the frame while offering an unwanted word
        @(posedge clk); #1;
        bus.frame_ready = 1'b0;
        run_frame(F1_W, 6, F1_D, 6'b000000, 1'b0, 1'b0, 1'b1, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h40A00000;
        bus.in_last  = 1'b0;
        for (int c = 0; c < 20; c++) begin
            chk("hold_frame_valid", bus.frame_valid, 1'b1);
            chk("hold_frame_data",  bus.frame_data,  F1_D);
            chk("hold_in_ready",    bus.in_ready,    1'b0);
            @(posedge clk); #1;
        end
        bus.in_valid    = 1'b0;
        bus.frame_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_frame_valid", bus.frame_valid, 1'b0);
        chk("release_in_ready",    bus.in_ready,    1'b1);

        // Reset while rd_idx == 2; that frame must never be presented
        run_frame(ST_W, 6, ST_D, 6'b011111, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk_reset_values("midreset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_frame(F1_W, 6, F1_D, 6'b000000, 1'b0, 1'b0, 1'b1, 1'b1);

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/float_frame_converter.md
# float_frame_converter

Frame sequencer that time-shares one combinational single-to-fixed converter across a burst of IEEE-754 single-precision sensor words (accel/gyro/mag channels) for the Madgwick filter core. It captures NUM_CH floats over a valid/ready stream, converts them one per cycle with saturation and NaN handling, and presents the whole frame as a parallel fixed-point bus with valid/ready toward the filter datapath.

## Interface
- NUM_CH, 6, channels per frame (2..16)
- INT_WIDTH, 8, integer bits of output, sign bit included
- FRACT_WIDTH, 8, fraction bits of output
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  in_data/in_last valid
- in_ready  out  1  block accepts a word this cycle
- in_data  in  32  IEEE-754 single
- in_last  in  1  final word of frame
- frame_valid  out  1  frame_data/flags valid
- frame_ready  in  1  consumer takes frame
- frame_data  out  NUM_CH*W  W=INT_WIDTH+FRACT_WIDTH; channel k at bits [k*W +: W], two's complement
- frame_sat  out  NUM_CH  per-channel saturation/NaN flag
- frame_short  out  1  frame ended by in_last before NUM_CH words
- busy  out  1  state != IDLE

## Operation
- States: IDLE, CAPTURE, CONVERT, PRESENT.
- IDLE: in_ready=1; first accepted word -> CAPTURE (stored at index 0).
- CAPTURE: in_ready=1; each accept (in_valid&in_ready) stores word at wr_idx, wr_idx++. Go to CONVERT when wr_idx reaches NUM_CH or in_last accepted. in_last on word NUM_CH-1 is normal; words after NUM_CH without in_last are not accepted (in_ready=0 in CONVERT).
- Short frame: in_last at index < NUM_CH-1 -> unfilled slots hold 32'h0 (convert to 0), frame_short=1.
- CONVERT: in_ready=0; rd_idx 0..NUM_CH-1, one channel per cycle through the converter; result and flag registered into slot rd_idx. After last channel -> PRESENT.
- PRESENT: frame_valid=1, outputs stable; on frame_ready -> IDLE, clear indices, frame_short, frame_sat.
- Arithmetic per channel: round to nearest; value = round(x*2^FRACT_WIDTH). If exponent==255 (NaN/Inf): NaN -> 0, +Inf -> max, -Inf -> min, flag=1. If |x| >= 2^(INT_WIDTH-1) or rounded result overflows W-bit signed range: clamp to max (2^(W-1)-1) or min (-2^(W-1)), flag=1. Denormals and values rounding to 0 -> 0, flag=0. Negative inputs: negate magnitude result.

## Timing
- Reset: state IDLE, in_ready=1, frame_valid=0, frame_data=0, frame_sat=0, frame_short=0, busy=0, indices 0.
- Accept rate: one word/cycle, no bubbles in IDLE/CAPTURE.
- Final word accepted at cycle t -> CONVERT cycles t+1..t+NUM_CH -> frame_valid=1 at t+NUM_CH+1.
- frame_ready with frame_valid=1 at cycle p -> frame_valid=0, in_ready=1 at p+1; no same-cycle accept of new word in PRESENT.
- frame_ready while frame_valid=0: ignored.
- Asynchronous reset mid-CAPTURE/CONVERT/PRESENT: immediate return to reset values; partial frame discarded.
- Converter is combinational; exactly one register stage between it and frame_data.

## Structure
- Package float_fix_pkg: IEEE-754 field constants (sign bit 31, exponent [30:23], bias 127, exponent 255 code), state enum, W helper.
- One sub-module: float_fix_conv_sat (combinational: rounding conversion plus saturation/NaN/Inf flag), instantiated once and shared via rd_idx mux.
- Capture buffer: NUM_CH x 32 registers; output bank: NUM_CH x W registers plus flags.

## Test plan
- Full frame, NUM_CH=6, back-to-back: 0.5, 1.0, 3.75, -2.5, 32'h3E2CD9DF (0.1688), 32'h3F800001 -> slots 0x0080, 0x0100, 0x03C0, 0xFD80, 0x002B, 0x0100; frame_sat=0; frame_valid exactly 7 cycles after last accept.
- Saturation: 1024.0, -1024.0, 127.999, +Inf, NaN -> 0x7FFF, 0x8000, 0x7FFF, 0x7FFF, 0x0000; frame_sat bits set on all five.
- Short frame: 3 words, in_last on third -> slots 3..5 = 0, frame_short=1, frame_valid after 6 CONVERT cycles.
- Backpressure: hold frame_ready=0 for 20 cycles -> frame_valid and data stable, in_ready=0, no words accepted; release -> in_ready=1 next cycle.
- Reset mid-CONVERT (rd_idx=2): rst_n low one cycle -> all outputs at reset values; next frame converts correctly with no stale data.
- Gapped input: in_valid toggled every other cycle -> identical results to back-to-back case.
